// File: rtl/wb_write_arbiter_if.sv
// Bundle of the register-file write-port arbiter's bus signals: pipeline write-back,
// long-latency result channel, decode hazard lookups and the registered RF write port.
interface wb_write_arbiter_if;
  logic        pipe_wr_en;
  logic [4:0]  pipe_wr_addr;
  logic [63:0] pipe_wr_data;

  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_addr;
  logic [63:0] lu_data;

  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic        pend_hazard1;
  logic        pend_hazard2;

  logic        drain_stall;

  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [63:0] rf_wr_data;

  // Arbiter side.
  modport slave (
    input  pipe_wr_en, pipe_wr_addr, pipe_wr_data,
    input  lu_valid, lu_addr, lu_data,
    output lu_ready,
    input  rd_addr1, rd_addr2,
    output pend_hazard1, pend_hazard2,
    output drain_stall,
    output rf_wr_en, rf_wr_addr, rf_wr_data
  );

  // Pipeline / long-latency unit / register-file side.
  modport master (
    output pipe_wr_en, pipe_wr_addr, pipe_wr_data,
    output lu_valid, lu_addr, lu_data,
    input  lu_ready,
    output rd_addr1, rd_addr2,
    input  pend_hazard1, pend_hazard2,
    input  drain_stall,
    input  rf_wr_en, rf_wr_addr, rf_wr_data
  );
endinterface

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: pipeline writes win, long-latency results queue in a
// small FIFO and drain into idle cycles, with starvation stall and pending-write hazards.
module wb_write_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic               clk,
  input  logic               reset,
  wb_write_arbiter_if.slave  bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int AGE_W = $clog2(STARVE_MAX + 1);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(STARVE_MAX);
  localparam logic [4:0]       XZR      = 5'd31;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_PIPE = 2'd1,
    SRC_FIFO = 2'd2
  } src_e;

  // FIFO storage
  logic [4:0]       addr_q [DEPTH];
  logic [63:0]      data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;

  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q, count_next;
  logic [AGE_W-1:0] age_q, age_next;
  logic             drain_stall_q;

  logic             rf_wr_en_q;
  logic [4:0]       rf_wr_addr_q;
  logic [63:0]      rf_wr_data_q;

  logic             pipe_wr;
  logic             enq;
  logic             pop;
  logic             not_empty;
  src_e             src;
  logic             hit1, hit2;

  assign not_empty = (count_q != '0);
  assign pipe_wr   = bus.pipe_wr_en && (bus.pipe_wr_addr != XZR);
  assign enq       = bus.lu_valid && bus.lu_ready;
  assign pop       = !pipe_wr && not_empty;

  // Ready comes from the registered count only: a full FIFO stays closed even while popping.
  assign bus.lu_ready = (count_q < FULL_CNT);

  // Write-source selection; an invalid (squashed or XZR) head still pops but writes nothing.
  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    src = SRC_NONE;
    if (pipe_wr) begin
      src = SRC_PIPE;
    end else if (not_empty && valid_q[head_q]) begin
      src = SRC_FIFO;
    end
  end

  always_comb begin
    count_next = count_q;
    unique case ({enq, pop})
      2'b10:   count_next = count_q + CNT_W'(1);
      2'b01:   count_next = count_q - CNT_W'(1);
      default: count_next = count_q;
    endcase
  end

  always_comb begin
    age_next = age_q;
    if (!not_empty || pop) begin
      age_next = '0;
    end else if (age_q != AGE_MAX) begin
      age_next = age_q + AGE_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      age_q         <= '0;
      drain_stall_q <= 1'b0;
    end else begin
      count_q       <= count_next;
      age_q         <= age_next;
      drain_stall_q <= (age_next == AGE_MAX);
      if (enq) tail_q <= tail_q + PTR_W'(1);
      if (pop) head_q <= head_q + PTR_W'(1);
    end
  end

  // Valid bits: WAW squash first, then pop, then enqueue, so a same-cycle enqueue counts as newer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (pipe_wr && (addr_q[i] == bus.pipe_wr_addr)) valid_q[i] <= 1'b0;
      end
      if (pop) valid_q[head_q] <= 1'b0;
      if (enq) valid_q[tail_q] <= (bus.lu_addr != XZR);
    end
  end

  // NOTE: payload storage has no reset; the reset valid bits and count already make it unobservable.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q] <= bus.lu_addr;
      data_q[tail_q] <= bus.lu_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_wr_en_q   <= 1'b0;
      rf_wr_addr_q <= '0;
      rf_wr_data_q <= '0;
    end else begin
      unique case (src)
        SRC_PIPE: begin
          rf_wr_en_q   <= 1'b1;
          rf_wr_addr_q <= bus.pipe_wr_addr;
          rf_wr_data_q <= bus.pipe_wr_data;
        end
        SRC_FIFO: begin
          rf_wr_en_q   <= 1'b1;
          rf_wr_addr_q <= addr_q[head_q];
          rf_wr_data_q <= data_q[head_q];
        end
        default: rf_wr_en_q <= 1'b0;
      endcase
    end
  end

  // Decode hazard lookup against queued entries plus an enqueue landing this cycle.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == bus.rd_addr1)) hit1 = 1'b1;
      if (valid_q[i] && (addr_q[i] == bus.rd_addr2)) hit2 = 1'b1;
    end
    if (enq && (bus.lu_addr == bus.rd_addr1)) hit1 = 1'b1;
    if (enq && (bus.lu_addr == bus.rd_addr2)) hit2 = 1'b1;
  end

  assign bus.pend_hazard1 = hit1 && (bus.rd_addr1 != XZR);
  assign bus.pend_hazard2 = hit2 && (bus.rd_addr2 != XZR);
  assign bus.drain_stall  = drain_stall_q;
  assign bus.rf_wr_en     = rf_wr_en_q;
  assign bus.rf_wr_addr   = rf_wr_addr_q;
  assign bus.rf_wr_data   = rf_wr_data_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: hand-computed expectations for pipe stream, drain,
// full FIFO, starvation, WAW squash, XZR handling and mid-operation reset.
module tb_wb_write_arbiter;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  wb_write_arbiter_if bus ();

  wb_write_arbiter #(
    .DEPTH      (2),
    .STARVE_MAX (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.pipe_wr_en   = 1'b0;
    bus.pipe_wr_addr = '0;
    bus.pipe_wr_data = '0;
    bus.lu_valid     = 1'b0;
    bus.lu_addr      = '0;
    bus.lu_data      = '0;
    bus.rd_addr1     = '0;
    bus.rd_addr2     = '0;
  endtask

  task automatic pipe(input logic [4:0] a, input logic [63:0] d);
    bus.pipe_wr_en   = 1'b1;
    bus.pipe_wr_addr = a;
    bus.pipe_wr_data = d;
  endtask

  task automatic lu(input logic [4:0] a, input logic [63:0] d);
    bus.lu_valid = 1'b1;
    bus.lu_addr  = a;
    bus.lu_data  = d;
  endtask

  task automatic check_rf(input string tag, input logic en, input logic [4:0] a,
                          input logic [63:0] d);
    check({tag, "_en"},   64'(bus.rf_wr_en),   64'(en));
    check({tag, "_addr"}, 64'(bus.rf_wr_addr), 64'(a));
    check({tag, "_data"}, bus.rf_wr_data,      d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle();
    reset = 1'b0;
    #12;
    check_rf("rst", 1'b0, 5'd0, 64'd0);
    check("rst_ready", 64'(bus.lu_ready),     64'd1);
    check("rst_stall", 64'(bus.drain_stall),  64'd0);
    check("rst_hz1",   64'(bus.pend_hazard1), 64'd0);
    #5 reset = 1'b1;
    tick();

    // Pipe-only stream, then an XZR pipe write that must not reach the RF.
    for (int i = 1; i <= 5; i++) begin
      pipe(5'(i), 64'(i * 16));
      tick();
      check_rf("pipe", 1'b1, 5'(i), 64'(i * 16));
    end
    pipe(5'd31, 64'h99);
    tick();
    check_rf("pipe_xzr", 1'b0, 5'd5, 64'h50);
    idle();

    // Long-latency drain with hazard window N, N+1.
    lu(5'd7, 64'hDEAD);
    bus.rd_addr1 = 5'd7;
    #1;
    check("drain_ready", 64'(bus.lu_ready), 64'd1);
    check("drain_hz_n",  64'(bus.pend_hazard1), 64'd1);
    tick();
    bus.lu_valid = 1'b0;
    #1;
    check("drain_hz_n1", 64'(bus.pend_hazard1), 64'd1);
    check("drain_en_n1", 64'(bus.rf_wr_en), 64'd0);
    tick();
    check_rf("drain", 1'b1, 5'd7, 64'hDEAD);
    check("drain_hz_n2", 64'(bus.pend_hazard1), 64'd0);
    idle();

    // Full FIFO while the pipe writes every cycle; third result held until a pop.
    pipe(5'd10, 64'h1010); lu(5'd3, 64'h333);
    #1 check("full_rdy0", 64'(bus.lu_ready), 64'd1);
    tick();
    pipe(5'd11, 64'h1111); lu(5'd4, 64'h444);
    #1 check("full_rdy1", 64'(bus.lu_ready), 64'd1);
    tick();
    pipe(5'd12, 64'h1212); lu(5'd5, 64'h555);
    #1 check("full_rdy2", 64'(bus.lu_ready), 64'd0);
    tick();
    check_rf("full_pipe", 1'b1, 5'd12, 64'h1212);
    bus.pipe_wr_en = 1'b0;
    #1 check("full_rdy3", 64'(bus.lu_ready), 64'd0);
    tick();
    check_rf("full_x3", 1'b1, 5'd3, 64'h333);
    #1 check("full_rdy4", 64'(bus.lu_ready), 64'd1);
    tick();
    bus.lu_valid = 1'b0;
    check_rf("full_x4", 1'b1, 5'd4, 64'h444);
    tick();
    check_rf("full_x5", 1'b1, 5'd5, 64'h555);
    tick();
    check("full_empty_en", 64'(bus.rf_wr_en), 64'd0);
    idle();

    // Starvation: head waits under continuous pipe writes until drain_stall, then drains.
    pipe(5'd1, 64'h11); lu(5'd20, 64'h2020);
    tick();
    bus.lu_valid = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      check($sformatf("stall_c%0d", k), 64'(bus.drain_stall), 64'(k == 9));
      pipe(5'(k), 64'(k));
      tick();
    end
    check("stall_hold", 64'(bus.drain_stall), 64'd1);
    check_rf("stall_pipe_wins", 1'b1, 5'd9, 64'd9);
    bus.pipe_wr_en = 1'b0;
    tick();
    check_rf("stall_drain", 1'b1, 5'd20, 64'h2020);
    check("stall_clear", 64'(bus.drain_stall), 64'd0);
    idle();

    // WAW squash: a younger pipe write to X9 kills the queued X9 result.
    lu(5'd9, 64'hAAAA);
    tick();
    bus.lu_valid = 1'b0;
    pipe(5'd9, 64'hBBBB);
    bus.rd_addr2 = 5'd9;
    #1 check("waw_hz_before", 64'(bus.pend_hazard2), 64'd1);
    tick();
    check_rf("waw_pipe", 1'b1, 5'd9, 64'hBBBB);
    bus.pipe_wr_en = 1'b0;
    #1 check("waw_hz_after", 64'(bus.pend_hazard2), 64'd0);
    tick();
    check_rf("waw_squash_pop", 1'b0, 5'd9, 64'hBBBB);
    idle();

    // Same-cycle enqueue to the pipe's address is newer and survives.
    pipe(5'd12, 64'h1212); lu(5'd12, 64'hCCCC);
    bus.rd_addr1 = 5'd12;
    #1 check("newer_hz0", 64'(bus.pend_hazard1), 64'd1);
    tick();
    bus.lu_valid   = 1'b0;
    bus.pipe_wr_en = 1'b0;
    #1 check("newer_hz1", 64'(bus.pend_hazard1), 64'd1);
    tick();
    check_rf("newer_write", 1'b1, 5'd12, 64'hCCCC);
    idle();

    // XZR long-latency result: accepted, no hazard, pops without a write.
    lu(5'd31, 64'h3131);
    bus.rd_addr1 = 5'd31;
    #1 check("xzr_lu_hz", 64'(bus.pend_hazard1), 64'd0);
    tick();
    bus.lu_valid = 1'b0;
    tick();
    check_rf("xzr_lu_pop", 1'b0, 5'd12, 64'hCCCC);
    idle();

    // Reset mid-operation with two queued entries and an RF write in flight.
    pipe(5'd2, 64'h22); lu(5'd13, 64'h1313);
    tick();
    pipe(5'd3, 64'h33); lu(5'd14, 64'h1414);
    tick();
    idle();
    bus.rd_addr1 = 5'd13;
    #1;
    check("mid_hz",    64'(bus.pend_hazard1), 64'd1);
    check("mid_ready", 64'(bus.lu_ready),     64'd0);
    check("mid_en",    64'(bus.rf_wr_en),     64'd1);
    #2 reset = 1'b0;
    #1;
    check_rf("mid_rst", 1'b0, 5'd0, 64'd0);
    check("mid_rst_ready", 64'(bus.lu_ready),     64'd1);
    check("mid_rst_hz",    64'(bus.pend_hazard1), 64'd0);
    check("mid_rst_stall", 64'(bus.drain_stall),  64'd0);
    #2 reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("post_rst_en_c%0d", c), 64'(bus.rf_wr_en), 64'd0);
    end
    check("post_rst_ready", 64'(bus.lu_ready), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/wb_write_arbiter.md
# wb_write_arbiter

Arbiter for the single register-file write port shared between the in-order pipeline write-back stage and a long-latency result unit (multi-cycle multiply/divide or normalise). Pipeline writes always win. Long-latency results queue in a small FIFO and drain into idle write-port cycles. A starvation counter forces a pipeline bubble when a queued result waits too long. Per-entry scoreboard compare lets decode detect reads of registers whose results are still queued.

## Interface
Parameters:
- DEPTH, 2: FIFO entries for long-latency results (power of two, ≥2).
- STARVE_MAX, 8: cycles the FIFO head may wait before drain_stall asserts.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset; asynchronous and active-low.
- pipe_wr_en  in  1  pipeline WB write request (RegWrite at WB).
- pipe_wr_addr  in  5  pipeline destination register.
- pipe_wr_data  in  64  pipeline write data.
- lu_valid  in  1  long-latency unit has a result.
- lu_ready  out  1  FIFO can accept; equals (count < DEPTH).
- lu_addr  in  5  long-latency destination register.
- lu_data  in  64  long-latency result.
- rd_addr1, rd_addr2  in  5 each  decode source registers.
- pend_hazard1, pend_hazard2  out  1 each  source matches a pending long-latency write.
- drain_stall  out  1  pipeline must issue no WB write next cycle.
- rf_wr_en  out  1  register-file write enable (registered).
- rf_wr_addr  out  5  register-file write address (registered).
- rf_wr_data  out  64  register-file write data (registered).

## Operation
- Effective pipe write: pipe_wr = pipe_wr_en && pipe_wr_addr != 31. Writes to X31 (XZR) are dropped from every source.
- Enqueue: occurs when lu_valid && lu_ready. The entry is stored as {valid=1, addr, data} at the tail. An lu_addr of 31 is accepted and stored with valid=0.
- Selection, each cycle, in priority order:
  - pipe_wr: the pipe write is selected.
  - Else if count > 0: the head is popped. It is written only if its valid bit is 1; an invalid head pops with rf_wr_en=0.
  - Else: idle.
- Output register: the selected write loads rf_wr_en/addr/data on the next edge. When nothing is written, rf_wr_en=0 and addr/data hold their previous values.
- WAW squash: an accepted pipe_wr to address X clears the valid bit of every queued entry with addr X. An entry enqueued in the same cycle is not squashed; it is treated as newer.
- Hazard: pend_hazardN=1 when rd_addrN != 31 and either condition holds:
  - it matches a valid queued entry, or
  - it matches lu_addr of an enqueue happening this cycle.
  - Purely combinational.
- Starvation:
  - age counter: cleared when count==0 or on a head pop; otherwise increments while count>0, saturating at STARVE_MAX.
  - drain_stall = (age == STARVE_MAX), registered.
  - The pipeline guarantees pipe_wr_en=0 in the cycle after drain_stall=1, so the head drains.
  - If pipe_wr_en is 1 anyway, the pipe still wins. drain_stall stays asserted until a pop.
- Count arithmetic: count is log2(DEPTH)+1 bits. Enqueue and pop in the same cycle leaves count unchanged. Head/tail pointers wrap modulo DEPTH.
- No enqueue can occur when full, because lu_ready=0.

## Timing
- Pipe write in cycle N: rf_wr_en=1 in cycle N+1, with one-cycle latency.
- Long-latency result accepted in cycle N: earliest pop in N+1, earliest rf_wr_en in N+2.
- lu_ready is derived from the registered count: no same-cycle pass-through, and no full-and-pop bypass.
- Reset, asynchronous, asserted at any time:
  - count, pointers, age and all valid bits go to 0.
  - rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0.
  - drain_stall=0, lu_ready=1, pend_hazard*=0 (inputs permitting).
  - Queued results are discarded.

## Test plan
- Pipe-only stream: pipe_wr_en=1 to X1..X5 with data 0x10..0x50 on consecutive cycles → rf_wr_* shows each one cycle later, in order; X31 pipe write → rf_wr_en=0.
- Long-latency drain: lu writes X7=0xDEAD at cycle N while pipe is idle → rf_wr_en=1, addr=7, data=0xDEAD at N+2; pend_hazard1=1 for rd_addr1=7 during N and N+1, then 0.
- Full FIFO: two lu enqueues while pipe writes every cycle → lu_ready=0 after the second. Third lu_valid is held until a pop. Order is preserved: X3 then X4.
- Starvation: queued entry plus continuous pipe writes → drain_stall rises once age reaches 8. The bench then drops pipe_wr_en for one cycle → head is written and drain_stall clears.
- WAW squash: queue X9=0xAAAA, then pipe writes X9=0xBBBB → only 0xBBBB is written. The squashed head pops with rf_wr_en=0 and pend_hazard for X9 drops.
- Reset mid-operation: assert reset with 2 queued entries and rf_wr_en=1 → all outputs take their reset values immediately, lu_ready=1, and no queued write appears after release.
